// File: rtl/rv_div_pkg.sv
// Shared types and constants for the iterative RISC-V divide unit.
package rv_div_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   // Special-case results at the default width
   localparam logic [XLEN-1:0] DIV0_QUOT    = '1;
   localparam logic [XLEN-1:0] OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] OVF_DIVISOR  = '1;
   localparam logic [XLEN-1:0] OVF_QUOT     = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] OVF_REM      = '0;

   function automatic logic op_is_signed(div_op_e op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/rv_div_step.sv
// One restoring division iteration: shift, trial subtract, select.
module rv_div_step
   import rv_div_pkg::*;
#(
   parameter int XLEN = rv_div_pkg::XLEN
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quot_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quot_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Partial remainder is always below the divisor, so the restored value fits XLEN bits
   always_comb begin
      shifted = {rem_i, quot_i[XLEN-1]};
      diff    = shifted - {1'b0, divisor_i};
      rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quot_o  = {quot_i[XLEN-2:0], ~diff[XLEN]};
   end

endmodule

// File: rtl/rv_div_unit.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU), one bit per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start_i; result_o holds last result
// ST_CALC | one restoring iteration per edge on |a| / |b|
// ST_DONE | result_o valid, done_o high for exactly one cycle
module rv_div_unit
   import rv_div_pkg::*;
#(
   parameter int XLEN = rv_div_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o,
   output logic            done_o
);

   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   div_state_e       state;
   div_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quot_q;
   logic [XLEN-1:0]  divisor_q;
   logic             neg_quot_q;
   logic             neg_rem_q;

   div_op_e          op_in;
   logic             in_signed;
   logic             a_neg;
   logic             b_neg;
   logic [XLEN-1:0]  a_abs;
   logic [XLEN-1:0]  b_abs;
   logic             in_ovf;
   logic [XLEN-1:0]  step_rem;
   logic [XLEN-1:0]  step_quot;
   logic [XLEN-1:0]  calc_result;

   // Operand magnitudes and sign flags for the request on the inputs
   always_comb begin
      op_in     = div_op_e'(op_i);
      in_signed = op_is_signed(op_in);
      a_neg     = in_signed & a_i[XLEN-1];
      b_neg     = in_signed & b_i[XLEN-1];
      a_abs     = a_neg ? -a_i : a_i;
      b_abs     = b_neg ? -b_i : b_i;
      in_ovf    = in_signed && (a_i == MIN_NEG) && (b_i == '1);
   end

   rv_div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .quot_o    (step_quot)
   );

   // Sign fix-up applied to the final iteration's outputs
   always_comb begin
      if (op_is_rem(op_q)) begin
         calc_result = neg_rem_q ? -step_rem : step_rem;
      end else begin
         calc_result = neg_quot_q ? -step_quot : step_quot;
      end
   end

   // Control FSM with registered busy/done and held result
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= ST_IDLE;
         op_q       <= OP_DIV;
         cnt        <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         divisor_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_o   <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i && !flush_i) begin
                  op_q       <= op_in;
                  cnt        <= '0;
                  rem_q      <= '0;
                  quot_q     <= a_abs;
                  divisor_q  <= b_abs;
                  neg_quot_q <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  if (b_i == '0) begin
                     state    <= ST_DONE;
                     done_o   <= 1'b1;
                     result_o <= op_is_rem(op_in) ? a_i : '1;
                  end else if (in_ovf) begin
                     state    <= ST_DONE;
                     done_o   <= 1'b1;
                     result_o <= op_is_rem(op_in) ? '0 : MIN_NEG;
                  end else begin
                     state  <= ST_CALC;
                     busy_o <= 1'b1;
                  end
               end
            end
            ST_CALC: begin
               if (flush_i) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  rem_q  <= step_rem;
                  quot_q <= step_quot;
                  cnt    <= cnt + 1'b1;
                  if (cnt == LAST_ITER) begin
                     state    <= ST_DONE;
                     busy_o   <= 1'b0;
                     done_o   <= 1'b1;
                     result_o <= calc_result;
                  end
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_o <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_div_unit.sv
// Bench for rv_div_unit: arithmetic reference model plus directed vectors.
module tb_rv_div_unit;
   import rv_div_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op_r = 2'b00;
   logic [31:0] a_r = '0;
   logic [31:0] b_r = '0;
   logic        flush = 1'b0;
   logic [31:0] result;
   logic        busy;
   logic        done;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state (spec-level: active/remaining cycles/held result)
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res  = '0;
   logic [31:0] m_pend = '0;

   rv_div_unit #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .start_i  (start),
      .op_i     (op_r),
      .a_i      (a_r),
      .b_i      (b_r),
      .flush_i  (flush),
      .result_o (result),
      .busy_o   (busy),
      .done_o   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic bit model_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1'b1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int signed sa;
      int signed sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
      case (op)
         OP_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
         OP_REM:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
         OP_DIVU: return a / b;
         default: return a % b;
      endcase
   endfunction

   // model: divide accepted in idle, result after 32 calc cycles or at once for special cases
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_left = 0;
         m_res  = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_busy) begin
         if (flush) m_busy = 1'b0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_res  = m_pend;
            end
         end
      end else if (start && !flush) begin
         m_pend = model_result(op_r, a_r, b_r);
         if (model_special(op_r, a_r, b_r)) begin
            m_done = 1'b1;
            m_res  = m_pend;
         end else begin
            m_busy = 1'b1;
            m_left = 32;
         end
      end
   end

   // per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc_done", {31'd0, done}, {31'd0, m_done});
      check("cyc_result", result, m_res);
   end

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input bit no_wait);
      int n;
      int nb;
      if (!no_wait) @(negedge clk);
      #2;
      start = 1'b1;
      op_r  = op;
      a_r   = a;
      b_r   = b;
      @(negedge clk);
      start = 1'b0;
      n  = 1;
      nb = 0;
      while (!done && n < 60) begin
         if (busy) nb++;
         @(negedge clk);
         n++;
      end
      check({name, "_done"}, {31'd0, done}, 32'd1);
      check({name, "_lat"}, n, exp_lat);
      check({name, "_res"}, result, exp_res);
      check({name, "_busycyc"}, nb, exp_lat - 1);
   endtask

   initial begin
      int n;
      int ndone;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_result", result, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);

      // pin the model against hand-computed values
      check("model_divu", model_result(OP_DIVU, 32'd100, 32'd7), 32'd14);
      check("model_rem_neg", model_result(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check("model_div_neg", model_result(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check("model_div0", model_result(OP_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
      check("model_remu0", model_result(OP_REMU, 32'd5, 32'd0), 32'd5);
      check("model_ovf_q", model_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      check("model_ovf_r", model_result(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);
      check("model_rem_sgn", model_result(OP_REM, 32'd7, 32'hFFFF_FFFE), 32'd1);

      #2 rst_n = 1'b1;

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
      run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
      run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
      run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 1'b0);
      run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
      run_op("rem_m9_0", OP_REM, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1, 1'b0);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

      // start during CALC is ignored; original result delivered
      @(negedge clk);
      #2;
      start = 1'b1; op_r = OP_DIVU; a_r = 32'd1000; b_r = 32'd10;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 60) begin
         if (n == 5) begin
            start = 1'b1; op_r = OP_DIV; a_r = 32'd7; b_r = 32'd0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("ign_start_lat", n, 33);
      check("ign_start_res", result, 32'd100);

      // flush at iteration 10: back to idle, no done, result held
      @(negedge clk);
      #2;
      start = 1'b1; op_r = OP_DIVU; a_r = 32'd1000; b_r = 32'd3;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 45; k++) begin
         flush = (k == 10);
         if (done) ndone++;
         @(negedge clk);
      end
      flush = 1'b0;
      check("flush_no_done", ndone, 0);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_res", result, 32'd100);

      // flush beats start in idle
      #2;
      start = 1'b1; flush = 1'b1; op_r = OP_DIV; a_r = 32'd9; b_r = 32'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_idle_busy", {31'd0, busy}, 32'd0);
      check("flush_idle_done", {31'd0, done}, 32'd0);
      check("flush_idle_res", result, 32'd100);

      // reset during iteration 20 discards the operation
      #2;
      start = 1'b1; op_r = OP_DIVU; a_r = 32'h1234_5678; b_r = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_res", result, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run_op("divu_after_rst", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rv_div_unit.md
RV_DIV_UNIT -- requirements
Module: rv_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have start_i  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have op_i  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have a_i  input  XLEN  dividend (rs1).
REQ-007 SHALL have b_i  input  XLEN  divisor (rs2).
REQ-008 SHALL have flush_i  input  1  synchronous abort of an operation in progress.
REQ-009 SHALL have result_o  output  XLEN  quotient or remainder per captured op.
REQ-010 SHALL have busy_o  output  1  high while in CALC.
REQ-011 SHALL have done_o  output  1  one-cycle pulse, result_o valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-013 In IDLE with start_i=1 at edge E0, SHALL capture op_i, |a_i|, |b_i| (signed ops) and the result sign flags.
REQ-014 Normal case: SHALL enter CALC at E0, perform one restoring iteration per edge E1..E32, enter DONE after E32; done_o high in cycle following E32 (33-cycle latency).
REQ-015 Each iteration SHALL shift {rem,quot} left one bit, compute rem-divisor in XLEN+1 bits, keep the difference and set quot LSB=1 if non-negative, else restore and set LSB=0.
REQ-016 Iteration counter SHALL be 6 bits, cleared at E0, terminating after exactly XLEN iterations.
REQ-017 Divisor zero: SHALL bypass CALC, enter DONE at E0; quotient all ones, remainder = a_i unchanged (signed and unsigned).
REQ-018 Signed overflow (DIV/REM, a_i=0x80000000, b_i=0xFFFFFFFF): SHALL bypass CALC; quotient 0x80000000, remainder 0.
REQ-019 Signed ops: quotient negated when operand signs differ; remainder takes dividend sign; negation in two's complement on the DONE transition.
REQ-020 result_o SHALL hold the last result from DONE until the next accepted start; undefined-value glitches on result_o during CALC are not permitted (hold previous).
REQ-021 start_i SHALL be ignored in CALC and DONE; no queuing.
REQ-022 flush_i in CALC or DONE SHALL return to IDLE at that edge with no done_o pulse; result_o unchanged; flush_i wins over start_i in IDLE (no acceptance).
REQ-023 busy_o SHALL be high exactly while state=CALC; done_o exactly while state=DONE.

Reset
REQ-024 rst_n_i low SHALL immediately force IDLE, counter 0, result_o=0, busy_o=0, done_o=0, working registers 0.
REQ-025 Reset asserted mid-CALC SHALL discard the operation; no done_o after release.
REQ-026 First start_i SHALL be accepted on the first rising edge with rst_n_i high.

Structure
REQ-027 Shared package SHALL hold XLEN, op encodings (OP_DIV..OP_REMU), FSM state encoding, and special-case constants.
REQ-028 One sub-module, rv_div_step, SHALL implement a single combinational restoring iteration (XLEN+1-bit subtract, select, quotient bit).
REQ-029 Implementation SHALL be synthesizable, single clock domain, no latches.

Verification
REQ-030 DIVU 100/7 -> result_o=14, done_o exactly 33 cycles after accept, busy_o high 32 cycles.
REQ-031 REM 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD (-3).
REQ-032 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done_o one cycle after accept, busy_o never high.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; one-cycle latency.
REQ-034 start_i pulsed during CALC with new operands -> ignored, original result delivered; then flush_i at iteration 10 -> IDLE, no done_o.
REQ-035 rst_n_i low at iteration 20 -> outputs 0 immediately; after release DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF in 33 cycles.
